// File: rtl/exe_stage_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: decoded operands in, branch redirect and EX/MEM fields out.
// master is the pipeline side driving decode fields; slave is the execute stage.
interface exe_stage_if;
  logic        freeze;
  logic        flush_in;
  logic        wb_en_in;
  logic [1:0]  mem_signal_in;
  logic [1:0]  branch_type_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] val1_in;
  logic [31:0] val2_in;
  logic [31:0] reg2_in;
  logic [31:0] pc_in;
  logic [4:0]  dest_in;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        wb_en_out;
  logic [1:0]  mem_signal_out;
  logic [31:0] alu_result_out;
  logic [31:0] st_val_out;
  logic [4:0]  dest_out;

  modport master (
    output freeze, flush_in, wb_en_in, mem_signal_in, branch_type_in, exe_cmd_in,
           val1_in, val2_in, reg2_in, pc_in, dest_in,
    input  branch_taken, branch_addr, wb_en_out, mem_signal_out, alu_result_out,
           st_val_out, dest_out
  );

  modport slave (
    input  freeze, flush_in, wb_en_in, mem_signal_in, branch_type_in, exe_cmd_in,
           val1_in, val2_in, reg2_in, pc_in, dest_in,
    output branch_taken, branch_addr, wb_en_out, mem_signal_out, alu_result_out,
           st_val_out, dest_out
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: ALU + branch resolution, 1-cycle latency into EX/MEM; branch redirect is combinational.
// freeze holds all state and suppresses redirect; a taken branch annuls the next BR_SHADOW instructions.
module exe_stage #(
  parameter int BR_SHADOW = 2
) (
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave ex
);

  localparam int CW = $clog2(BR_SHADOW + 1);

  logic [CW-1:0] shadow_cnt;
  logic          valid;
  logic          cond;
  logic [31:0]   alu;
  logic [1:0]    mem_norm;
  logic [4:0]    shamt;

  assign shamt    = ex.val2_in[4:0];
  assign valid    = !ex.flush_in && (shadow_cnt == '0);
  assign mem_norm = (ex.mem_signal_in == 2'b11) ? 2'b00 : ex.mem_signal_in;

  always_comb begin
    cond = 1'b0;
    case (ex.branch_type_in)
      2'b01:   cond = (ex.val1_in == 32'd0);
      2'b10:   cond = (ex.val1_in != ex.reg2_in);
      2'b11:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign ex.branch_taken = !rst && !ex.freeze && valid && cond;
  assign ex.branch_addr  = ex.pc_in + (ex.val2_in << 2);

  always_comb begin
    alu = '0;
    case (ex.exe_cmd_in)
      4'b0000: alu = ex.val1_in + ex.val2_in;
      4'b0010: alu = ex.val1_in - ex.val2_in;
      4'b0100: alu = ex.val1_in & ex.val2_in;
      4'b0101: alu = ex.val1_in | ex.val2_in;
      4'b0110: alu = ~(ex.val1_in | ex.val2_in);
      4'b0111: alu = ex.val1_in ^ ex.val2_in;
      4'b1000: alu = ex.val1_in << shamt;
      4'b1001: alu = $unsigned($signed(ex.val1_in) >>> shamt);
      4'b1010: alu = ex.val1_in >> shamt;
      default: alu = '0;
    endcase
  end

  // branch_taken already excludes freeze, so the counter reload never fires while frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_cnt        <= '0;
      ex.wb_en_out      <= 1'b0;
      ex.mem_signal_out <= 2'b00;
      ex.alu_result_out <= 32'd0;
      ex.st_val_out     <= 32'd0;
      ex.dest_out       <= 5'd0;
    end else begin
      if (ex.branch_taken)
        shadow_cnt <= CW'(BR_SHADOW);
      else if (!ex.freeze && shadow_cnt != '0)
        shadow_cnt <= shadow_cnt - CW'(1);

      if (!ex.freeze) begin
        ex.wb_en_out      <= valid && ex.wb_en_in;
        ex.mem_signal_out <= valid ? mem_norm : 2'b00;
        ex.alu_result_out <= alu;
        ex.st_val_out     <= ex.reg2_in;
        ex.dest_out       <= ex.dest_in;
      end
    end
  end

endmodule
